// File: rtl/imem_loader_if.sv
// Instruction-field stream into the loader: assembler-level fields plus valid/ready.
// Also holds the shared width macros for the instruction-memory write port.
`ifndef IMEM_LOADER_DEFS
`define IMEM_LOADER_DEFS
`define WORD 64
`define INSTR_LEN 32
`endif

interface imem_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [10:0] opcode;
  logic [4:0]  rd;
  logic [4:0]  rn;
  logic [4:0]  rm;
  logic [5:0]  shamt;
  logic [25:0] imm;

  modport master (
    output in_valid, fmt, opcode, rd, rn, rm, shamt, imm,
    input  in_ready
  );

  modport slave (
    input  in_valid, fmt, opcode, rd, rn, rm, shamt, imm,
    output in_ready
  );
endinterface

// File: rtl/imem_loader.sv
// Encodes LEGv8 instruction fields (R/I/D/B/CB) and writes them to consecutive
// instruction-memory words, one per cycle, with a one-cycle write register.
module imem_loader #(
  parameter int SIZE = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   finish,
  imem_loader_if.slave           in_if,
  output logic                   mem_we,
  output logic [`WORD-1:0]       mem_addr,
  output logic [`INSTR_LEN-1:0]  mem_wdata,
  output logic [`WORD-1:0]       count,
  output logic                   busy,
  output logic                   load_done,
  output logic                   err_range,
  output logic                   err_fmt
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  localparam logic [`WORD-1:0] SIZE_W = `WORD'(SIZE);

  state_t                  state;
  state_t                  state_next;
  logic [`INSTR_LEN-1:0]   enc_word;
  logic                    fmt_ok;
  logic                    imm_ok;
  logic                    accept;
  logic                    clear_load;

  // count already includes the word sitting in the write register, so it alone
  // bounds how many more words may be accepted.
  assign in_if.in_ready = (state == LOAD) && (count < SIZE_W) && !finish;
  assign accept         = in_if.in_valid && in_if.in_ready;
  assign clear_load     = start && ((state == IDLE) || (state == DONE));
  assign busy           = (state == LOAD) || (state == DRAIN);
  assign load_done      = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)  state_next = LOAD;
      LOAD:    if (finish) state_next = DRAIN;
      DRAIN:   state_next = DONE;
      DONE:    if (start)  state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  // Signed immediates are legal when every bit above the field matches its sign bit.
  always_comb begin
    enc_word = '0;
    fmt_ok   = 1'b1;
    imm_ok   = 1'b1;
    case (in_if.fmt)
      3'd0: enc_word = {in_if.opcode, in_if.rm, in_if.shamt, in_if.rn, in_if.rd};
      3'd1: begin
        enc_word = {in_if.opcode[10:1], in_if.imm[11:0], in_if.rn, in_if.rd};
        imm_ok   = (in_if.imm[25:12] == '0);
      end
      3'd2: begin
        enc_word = {in_if.opcode, in_if.imm[8:0], 2'b00, in_if.rn, in_if.rd};
        imm_ok   = (&in_if.imm[25:8]) || (~|in_if.imm[25:8]);
      end
      3'd3: enc_word = {in_if.opcode[10:5], in_if.imm};
      3'd4: begin
        enc_word = {in_if.opcode[10:3], in_if.imm[18:0], in_if.rd};
        imm_ok   = (&in_if.imm[25:18]) || (~|in_if.imm[25:18]);
      end
      default: fmt_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      count     <= '0;
      err_range <= 1'b0;
      err_fmt   <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (clear_load) begin
        count     <= '0;
        err_range <= 1'b0;
        err_fmt   <= 1'b0;
      end else if (accept) begin
        if (!fmt_ok) begin
          err_fmt <= 1'b1;
        end else if (!imm_ok) begin
          err_range <= 1'b1;
        end else begin
          mem_we    <= 1'b1;
          mem_addr  <= {count[`WORD-3:0], 2'b00};
          mem_wdata <= enc_word;
          count     <= count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (SIZE=4): encodings, range/format errors,
// full-memory stall, finish/valid collision and mid-load reset.
module tb_imem_loader;

  logic                  clk;
  logic                  reset;
  logic                  start;
  logic                  finish;
  logic                  mem_we;
  logic [`WORD-1:0]      mem_addr;
  logic [`INSTR_LEN-1:0] mem_wdata;
  logic [`WORD-1:0]      count;
  logic                  busy;
  logic                  load_done;
  logic                  err_range;
  logic                  err_fmt;
  int                    error_count;
  int                    check_count;

  imem_loader_if in_bus ();

  imem_loader #(.SIZE(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .finish    (finish),
    .in_if     (in_bus),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .count     (count),
    .busy      (busy),
    .load_done (load_done),
    .err_range (err_range),
    .err_fmt   (err_fmt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one instruction on the bus from the falling edge; valid stays up until dropped.
  task automatic applyStimulus(input logic [2:0] f, input logic [10:0] op, input logic [4:0] d,
                               input logic [4:0] n, input logic [4:0] m, input logic [5:0] sh,
                               input logic [25:0] im);
    @(negedge clk);
    in_bus.fmt      = f;
    in_bus.opcode   = op;
    in_bus.rd       = d;
    in_bus.rn       = n;
    in_bus.rm       = m;
    in_bus.shamt    = sh;
    in_bus.imm      = im;
    in_bus.in_valid = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_valid();
    @(negedge clk);
    in_bus.in_valid = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_finish();
    @(negedge clk);
    finish = 1'b1;
    step();
    finish = 1'b0;
    checkOutput("drain_busy", 64'(busy), 64'd1);
    step();
    checkOutput("done_flag", 64'(load_done), 64'd1);
  endtask

  initial begin
    error_count     = 0;
    check_count     = 0;
    reset           = 1'b0;
    start           = 1'b0;
    finish          = 1'b0;
    in_bus.in_valid = 1'b0;
    in_bus.fmt      = '0;
    in_bus.opcode   = '0;
    in_bus.rd       = '0;
    in_bus.rn       = '0;
    in_bus.rm       = '0;
    in_bus.shamt    = '0;
    in_bus.imm      = '0;
    #12;
    checkOutput("rst_we",     64'(mem_we), 64'd0);
    checkOutput("rst_addr",   mem_addr, 64'd0);
    checkOutput("rst_wdata",  64'(mem_wdata), 64'd0);
    checkOutput("rst_count",  count, 64'd0);
    checkOutput("rst_busy",   64'(busy), 64'd0);
    checkOutput("rst_done",   64'(load_done), 64'd0);
    checkOutput("rst_ready",  64'(in_bus.in_ready), 64'd0);
    checkOutput("rst_errs",   64'({err_range, err_fmt}), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // ADD X10, X19, X9
    do_start();
    checkOutput("start_busy", 64'(busy), 64'd1);
    applyStimulus(3'd0, 11'b10001011000, 5'd10, 5'd19, 5'd9, 6'd0, 26'd0);
    step();
    checkOutput("add_we",    64'(mem_we), 64'd1);
    checkOutput("add_addr",  mem_addr, 64'd0);
    checkOutput("add_wdata", 64'(mem_wdata), 64'h8B09026A);
    checkOutput("add_count", count, 64'd1);
    drop_valid();
    step();
    checkOutput("add_we_once", 64'(mem_we), 64'd0);
    do_finish();

    // Back-to-back D, B, CB, then an out-of-range D
    do_start();
    applyStimulus(3'd2, 11'b11111000010, 5'd9, 5'd22, 5'd0, 6'd0, 26'd64);
    checkOutput("ldur_ready", 64'(in_bus.in_ready), 64'd1);
    step();
    checkOutput("ldur_addr",  mem_addr, 64'd0);
    checkOutput("ldur_wdata", 64'(mem_wdata), 64'hF84402C9);
    applyStimulus(3'd3, 11'b00010100000, 5'd0, 5'd0, 5'd0, 6'd0, 26'd64);
    checkOutput("b_ready", 64'(in_bus.in_ready), 64'd1);
    step();
    checkOutput("b_we",    64'(mem_we), 64'd1);
    checkOutput("b_addr",  mem_addr, 64'd4);
    checkOutput("b_wdata", 64'(mem_wdata), 64'h14000040);
    checkOutput("b_count", count, 64'd2);
    applyStimulus(3'd4, 11'b10110100000, 5'd11, 5'd0, 5'd0, 6'd0, 26'h3FFFFFB);
    step();
    checkOutput("cb_addr",  mem_addr, 64'd8);
    checkOutput("cb_wdata", 64'(mem_wdata), 64'hB4FFFF6B);
    applyStimulus(3'd2, 11'b11111000010, 5'd9, 5'd22, 5'd0, 6'd0, 26'd300);
    step();
    checkOutput("range_we",    64'(mem_we), 64'd0);
    checkOutput("range_err",   64'(err_range), 64'd1);
    checkOutput("range_count", count, 64'd3);
    drop_valid();
    do_finish();
    checkOutput("range_sticky", 64'(err_range), 64'd1);

    // Fill a SIZE=4 memory with five R instructions
    do_start();
    checkOutput("restart_err", 64'(err_range), 64'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(3'd0, 11'b10001011000, 5'(i), 5'd1, 5'd2, 6'd0, 26'd0);
      step();
      checkOutput("fill_addr",  mem_addr, 64'(4 * i));
      checkOutput("fill_wdata", 64'(mem_wdata), 64'(32'h8B020020 | i));
    end
    checkOutput("full_ready", 64'(in_bus.in_ready), 64'd0);
    applyStimulus(3'd0, 11'b10001011000, 5'd4, 5'd1, 5'd2, 6'd0, 26'd0);
    step();
    checkOutput("full_we1", 64'(mem_we), 64'd0);
    step();
    checkOutput("full_we2",   64'(mem_we), 64'd0);
    checkOutput("full_count", count, 64'd4);
    drop_valid();
    do_finish();
    checkOutput("full_done_count", count, 64'd4);

    // Illegal format, then finish colliding with a valid instruction
    do_start();
    applyStimulus(3'd6, 11'b10001011000, 5'd1, 5'd1, 5'd1, 6'd0, 26'd0);
    step();
    checkOutput("fmt_we",    64'(mem_we), 64'd0);
    checkOutput("fmt_err",   64'(err_fmt), 64'd1);
    checkOutput("fmt_count", count, 64'd0);
    applyStimulus(3'd0, 11'b10001011000, 5'd1, 5'd1, 5'd1, 6'd0, 26'd0);
    finish = 1'b1;
    #1;
    checkOutput("collide_ready", 64'(in_bus.in_ready), 64'd0);
    step();
    finish = 1'b0;
    checkOutput("collide_we",    64'(mem_we), 64'd0);
    checkOutput("collide_count", count, 64'd0);
    drop_valid();
    step();
    checkOutput("collide_done", 64'(load_done), 64'd1);
    do_start();
    checkOutput("clear_fmt", 64'(err_fmt), 64'd0);
    applyStimulus(3'd0, 11'b10001011000, 5'd10, 5'd19, 5'd9, 6'd0, 26'd0);
    step();
    checkOutput("restart_addr",  mem_addr, 64'd0);
    checkOutput("restart_count", count, 64'd1);

    // Reset in the cycle after an accept
    applyStimulus(3'd0, 11'b10001011000, 5'd3, 5'd4, 5'd5, 6'd0, 26'd0);
    step();
    checkOutput("pre_rst_we", 64'(mem_we), 64'd1);
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_we",    64'(mem_we), 64'd0);
    checkOutput("mid_rst_addr",  mem_addr, 64'd0);
    checkOutput("mid_rst_wdata", 64'(mem_wdata), 64'd0);
    checkOutput("mid_rst_count", count, 64'd0);
    checkOutput("mid_rst_busy",  64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    step();
    checkOutput("idle_ready", 64'(in_bus.in_ready), 64'd0);
    step();
    checkOutput("idle_we",    64'(mem_we), 64'd0);
    checkOutput("idle_count", count, 64'd0);
    drop_valid();

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
